twofish_round_controller: RTL and testbench

//  Sequencing FSM for the Twofish block-cipher datapath: input whitening, NUM_ROUNDS F-rounds, output whitening.

---
 rtl/twofish_pkg.sv | 23 ++
 rtl/twofish_subkey_index_gen.sv | 20 ++
 rtl/twofish_round_controller.sv | 147 ++++++++++++++
 tb/tb_twofish_round_controller.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/twofish_pkg.sv
// Shared definitions for the Twofish round controller: state encoding,
// default round count and subkey base indices.
package twofish_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ROUND = 3'd2,
        ST_OUTW  = 3'd3,
        ST_DONE  = 3'd4
    } tf_state_e;

    localparam int NUM_ROUNDS_DEF = 16;
    localparam int IN_WHT_BASE    = 0;
    localparam int OUT_WHT_BASE   = 4;
    localparam int ROUND_SK_BASE  = 8;

    // Whitening group select for a given subkey base: K0..K3 -> 0, K4..K7 -> 1
    function automatic logic wht_group(input int base);
        return (base >= OUT_WHT_BASE);
    endfunction

endpackage

// File: rtl/twofish_subkey_index_gen.sv
// Maps the current round number to the pair of round subkey indices
// (2r+8, 2r+9); the mapping is identical for encrypt and decrypt.
module twofish_subkey_index_gen
    import twofish_pkg::*;
#(
    parameter int RND_W    = 5,
    parameter int SK_IDX_W = 6
) (
    input  logic [RND_W-1:0]    rnd,
    output logic [SK_IDX_W-1:0] sk_idx0,
    output logic [SK_IDX_W-1:0] sk_idx1
);

    logic [SK_IDX_W-1:0] even_idx;

    assign even_idx = SK_IDX_W'(ROUND_SK_BASE) + (SK_IDX_W'(rnd) << 1);
    assign sk_idx0  = even_idx;
    assign sk_idx1  = even_idx + SK_IDX_W'(1);

endmodule

// File: rtl/twofish_round_controller.sv
// Twofish block sequencer: IDLE -> LOAD -> ROUND x NUM_ROUNDS -> OUTW -> DONE.
// Define TWOFISH_DECRYPT_EN to add the mode port and decrypt ordering.
module twofish_round_controller
    import twofish_pkg::*;
#(
    parameter int NUM_ROUNDS = NUM_ROUNDS_DEF,
    parameter int SK_IDX_W   = 6,
    parameter int RND_W      = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                key_ready,
    input  logic                in_valid,
    output logic                in_ready,
`ifdef TWOFISH_DECRYPT_EN
    input  logic                mode,
`endif
    output logic                dp_load,
    output logic                dp_round_en,
    output logic                dp_out_wht,
    output logic                wsel,
    output logic [SK_IDX_W-1:0] sk_idx0,
    output logic [SK_IDX_W-1:0] sk_idx1,
    output logic [RND_W-1:0]    round_num,
    output logic                busy,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                key_lost
);

    localparam logic [RND_W-1:0] RND_LAST = RND_W'(NUM_ROUNDS - 1);
    localparam logic             WSEL_IN  = wht_group(IN_WHT_BASE);
    localparam logic             WSEL_OUT = wht_group(OUT_WHT_BASE);

    tf_state_e           state_p1, state_p0;
    logic [RND_W-1:0]    rnd_p1, rnd_p0;
    logic                mode_p1, mode_p0;
    logic                abort_p0;
    logic                mode_in;
    logic [RND_W-1:0]    rnd_final;
    logic [SK_IDX_W-1:0] sk0_p0, sk1_p0;

`ifdef TWOFISH_DECRYPT_EN
    assign mode_in = mode;
`else
    assign mode_in = 1'b0;
`endif

    assign rnd_final = mode_p1 ? '0 : RND_LAST;
    assign in_ready  = rst_n && key_ready && (state_p1 == ST_IDLE);

    always_comb begin
        state_p0 = state_p1;
        rnd_p0   = rnd_p1;
        mode_p0  = mode_p1;
        abort_p0 = 1'b0;
        case (state_p1)
            ST_IDLE: begin
                rnd_p0 = '0;
                if (in_valid && key_ready) begin
                    state_p0 = ST_LOAD;
                    mode_p0  = mode_in;
                end
            end
            ST_LOAD: begin
                if (!key_ready) begin
                    state_p0 = ST_IDLE;
                    abort_p0 = 1'b1;
                end else begin
                    state_p0 = ST_ROUND;
                    rnd_p0   = mode_p1 ? RND_LAST : '0;
                end
            end
            ST_ROUND: begin
                if (!key_ready) begin
                    state_p0 = ST_IDLE;
                    abort_p0 = 1'b1;
                end else if (rnd_p1 == rnd_final) begin
                    state_p0 = ST_OUTW;
                end else begin
                    rnd_p0 = mode_p1 ? (rnd_p1 - RND_W'(1)) : (rnd_p1 + RND_W'(1));
                end
            end
            ST_OUTW: begin
                if (!key_ready) begin
                    state_p0 = ST_IDLE;
                    abort_p0 = 1'b1;
                end else begin
                    state_p0 = ST_DONE;
                end
            end
            // Result is already captured, so a key loss here no longer matters
            ST_DONE: begin
                if (out_ready) state_p0 = ST_IDLE;
            end
            default: state_p0 = ST_IDLE;
        endcase
    end

    twofish_subkey_index_gen #(
        .RND_W    (RND_W),
        .SK_IDX_W (SK_IDX_W)
    ) u_sk_gen (
        .rnd     (rnd_p0),
        .sk_idx0 (sk0_p0),
        .sk_idx1 (sk1_p0)
    );

    // Stage p0 -> p1: outputs registered from the next-state decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p1    <= ST_IDLE;
            rnd_p1      <= '0;
            mode_p1     <= 1'b0;
            dp_load     <= 1'b0;
            dp_round_en <= 1'b0;
            dp_out_wht  <= 1'b0;
            wsel        <= 1'b0;
            sk_idx0     <= '0;
            sk_idx1     <= '0;
            round_num   <= '0;
            busy        <= 1'b0;
            out_valid   <= 1'b0;
            key_lost    <= 1'b0;
        end else begin
            state_p1    <= state_p0;
            rnd_p1      <= rnd_p0;
            mode_p1     <= mode_p0;
            dp_load     <= (state_p0 == ST_LOAD);
            dp_round_en <= (state_p0 == ST_ROUND);
            dp_out_wht  <= (state_p0 == ST_OUTW);
            out_valid   <= (state_p0 == ST_DONE);
            busy        <= (state_p0 != ST_IDLE);
            key_lost    <= abort_p0;
            round_num   <= (state_p0 == ST_ROUND) ? rnd_p0 : '0;
            sk_idx0     <= (state_p0 == ST_ROUND) ? sk0_p0 : '0;
            sk_idx1     <= (state_p0 == ST_ROUND) ? sk1_p0 : '0;
            if (state_p0 == ST_LOAD)
                wsel <= mode_p0 ? WSEL_OUT : WSEL_IN;
            else if (state_p0 == ST_OUTW)
                wsel <= mode_p0 ? WSEL_IN : WSEL_OUT;
            else
                wsel <= 1'b0;
        end
    end

endmodule

// File: tb/tb_twofish_round_controller.sv
// Bench for twofish_round_controller: timeline model checked every cycle plus
// directed literal checks on the key cycles of each scenario.
module tb_twofish_round_controller;

    localparam int NR  = 16;
    localparam int SKW = 6;
    localparam int RW  = 5;

`ifdef TWOFISH_DECRYPT_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n, key_ready, in_valid, mode, out_ready;
    logic           in_ready, dp_load, dp_round_en, dp_out_wht, wsel;
    logic [SKW-1:0] sk_idx0, sk_idx1;
    logic [RW-1:0]  round_num;
    logic           busy, out_valid, key_lost;

    always #5 clk = ~clk;

    twofish_round_controller #(.NUM_ROUNDS(NR), .SK_IDX_W(SKW), .RND_W(RW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_ready   (key_ready),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
`ifdef TWOFISH_DECRYPT_EN
        .mode        (mode),
`endif
        .dp_load     (dp_load),
        .dp_round_en (dp_round_en),
        .dp_out_wht  (dp_out_wht),
        .wsel        (wsel),
        .sk_idx0     (sk_idx0),
        .sk_idx1     (sk_idx1),
        .round_num   (round_num),
        .busy        (busy),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .key_lost    (key_lost)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: ph = cycles since the accepting edge (-1 when idle); DONE holds at NR+3
    int   ph     = -1;
    logic lost_m = 1'b0;
    logic mode_m = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph     <= -1;
            lost_m <= 1'b0;
            mode_m <= 1'b0;
        end else begin
            lost_m <= 1'b0;
            if (ph < 0) begin
                if (in_valid && key_ready) begin
                    ph     <= 1;
                    mode_m <= DEC_EN ? mode : 1'b0;
                end
            end else if (ph <= NR + 2) begin
                if (!key_ready) begin
                    ph     <= -1;
                    lost_m <= 1'b1;
                end else begin
                    ph <= ph + 1;
                end
            end else if (out_ready) begin
                ph <= -1;
            end
        end
    end

    logic e_ld, e_rn, e_ow, e_dn, e_wsel;
    int   e_r;

    always @(negedge clk) begin
        e_ld   = (ph == 1);
        e_rn   = (ph >= 2) && (ph <= NR + 1);
        e_ow   = (ph == NR + 2);
        e_dn   = (ph >= NR + 3);
        e_r    = e_rn ? (mode_m ? (NR - 1 - (ph - 2)) : (ph - 2)) : 0;
        e_wsel = e_ld ? mode_m : (e_ow ? ~mode_m : 1'b0);
        check("m_dp_load",     dp_load,     e_ld);
        check("m_dp_round_en", dp_round_en, e_rn);
        check("m_dp_out_wht",  dp_out_wht,  e_ow);
        check("m_out_valid",   out_valid,   e_dn);
        check("m_busy",        busy,        ph >= 1);
        check("m_key_lost",    key_lost,    lost_m);
        check("m_in_ready",    in_ready,    (ph < 0) && key_ready && rst_n);
        check("m_wsel",        wsel,        e_wsel);
        check("m_round_num",   round_num,   e_r);
        check("m_sk_idx0",     sk_idx0,     e_rn ? (2 * e_r + 8) : 0);
        check("m_sk_idx1",     sk_idx1,     e_rn ? (2 * e_r + 9) : 0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    int n;
    int cnt;

    initial begin
        rst_n     = 1'b0;
        key_ready = 1'b0;
        in_valid  = 1'b0;
        mode      = 1'b0;
        out_ready = 1'b0;
        #3;
        check("rst_busy",      busy,      0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready",  in_ready,  0);
        check("rst_dp_load",   dp_load,   0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        key_ready = 1'b1;
        #1 check("idle_in_ready", in_ready, 1);

        // Basic encrypt block, timeline and subkey trace
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("t1_load",      dp_load,     1);
        check("t1_load_wsel", wsel,        0);
        check("t1_in_ready",  in_ready,    0);
        step();
        check("t1_r0_en",   dp_round_en, 1);
        check("t1_r0_num",  round_num,   0);
        check("t1_r0_sk0",  sk_idx0,     8);
        check("t1_r0_sk1",  sk_idx1,     9);
        repeat (15) step();
        check("t1_r15_num", round_num,   15);
        check("t1_r15_sk0", sk_idx0,     38);
        check("t1_r15_sk1", sk_idx1,     39);
        step();
        check("t1_outw",      dp_out_wht, 1);
        check("t1_outw_wsel", wsel,       1);
        check("t1_outw_sk0",  sk_idx0,    0);
        step();
        check("t1_out_valid", out_valid, 1);

        // Result held with out_ready low; key loss while DONE does not abort
        for (int i = 0; i < 10; i++) begin
            key_ready = (i >= 3 && i <= 5) ? 1'b0 : 1'b1;
            step();
            check("t3_hold_valid", out_valid, 1);
            check("t3_hold_inrdy", in_ready,  0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("t3_idle_inrdy", in_ready,  1);
        check("t3_idle_valid", out_valid, 0);
        check("t3_idle_busy",  busy,      0);

        // Key loss at round 5
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (6) step();
        check("t4_r5", round_num, 5);
        key_ready = 1'b0;
        step();
        check("t4_key_lost", key_lost,    1);
        check("t4_busy",     busy,        0);
        check("t4_in_ready", in_ready,    0);
        check("t4_round_en", dp_round_en, 0);
        in_valid = 1'b1;
        step();
        check("t4_lost_pulse", key_lost, 0);
        repeat (3) step();
        check("t4_ignored", busy, 0);
        in_valid  = 1'b0;
        key_ready = 1'b1;
        step();

        // Asynchronous reset at round 7, then a clean block
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (8) step();
        check("t5_r7", round_num, 7);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_round_en", dp_round_en, 0);
        check("t5_rst_round",    round_num,   0);
        check("t5_rst_sk0",      sk_idx0,     0);
        check("t5_rst_busy",     busy,        0);
        check("t5_rst_in_ready", in_ready,    0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
        check("t5_latency", n, NR + 2);
        step();
        check("t5_back_idle", busy, 0);

        // Back-to-back blocks with in_valid and out_ready held high
        in_valid = 1'b1;
        cnt = 0;
        repeat (2 * (NR + 3) + 1) begin
            step();
            if (out_valid) cnt++;
        end
        in_valid = 1'b0;
        check("b2b_blocks", cnt, 2);
        step();
        step();
        out_ready = 1'b0;

`ifdef TWOFISH_DECRYPT_EN
        // Decrypt ordering; mode changes after accept must not matter
        mode     = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        mode     = 1'b0;
        check("t6_load_wsel", wsel, 1);
        step();
        check("t6_first_sk0", sk_idx0, 38);
        check("t6_first_sk1", sk_idx1, 39);
        repeat (15) step();
        check("t6_last_sk0", sk_idx0, 8);
        check("t6_last_sk1", sk_idx1, 9);
        step();
        check("t6_outw_wsel", wsel, 0);
        step();
        check("t6_out_valid", out_valid, 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
`endif

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
